// File: rtl/ccb_cmd_gen_if.sv
// CCB command bus plus one-shot request lines.
// The transmitter takes the slave side.
interface ccb_cmd_gen_if;
  logic       req_l1reset;
  logic       req_start;
  logic       req_stop;
  logic       req_user;
  logic [5:0] user_cmd;
  logic [5:0] ccb_cmd;
  logic       ccb_cmd_strobe;
  logic       ccb_bc0;
  logic       busy;
  logic       dropped;

  modport master (
    output req_l1reset, req_start, req_stop,
    output req_user, user_cmd,
    input  ccb_cmd, ccb_cmd_strobe, ccb_bc0,
    input  busy, dropped
  );

  modport slave (
    input  req_l1reset, req_start, req_stop,
    input  req_user, user_cmd,
    output ccb_cmd, ccb_cmd_strobe, ccb_bc0,
    output busy, dropped
  );
endinterface

// File: rtl/ccb_cmd_gen.sv
// Test-side CCB command transmitter: orbit counter,
// scheduled BC0 and arbitrated one-shot commands.
module ccb_cmd_gen #(
  parameter int unsigned CMD_GAP = 2
) (
  input  logic          clk,
  input  logic          hard_rst,
  input  logic          lhc_cycle_sel,
  input  logic          enable,
  input  logic          bc0_en,
  output logic [11:0]   orbit_bxn,
  output logic [15:0]   orbit_count,
  ccb_cmd_gen_if.slave  bus
);

  localparam logic [3:0] GAP = 4'(CMD_GAP);

  logic       f_stop;
  logic       f_l1;
  logic       f_start;
  logic       f_user;
  logic [5:0] ucode;
  logic [3:0] gap;

  logic [11:0] last_bx;
  logic        wrap;
  logic        bc0_go;
  logic        can;
  logic        iss_stop;
  logic        iss_l1;
  logic        iss_start;
  logic        iss_user;
  logic [5:0]  nxt_cmd;
  logic        nxt_stb;

  assign bus.busy = f_stop | f_l1 | f_start | f_user;

  // Wrap detection and priority pick for the next slot.
  always_comb begin
    last_bx = lhc_cycle_sel ? 12'd3563 : 12'd923;
    wrap    = enable && (orbit_bxn >= last_bx);
    bc0_go  = wrap && bc0_en;
    can     = !bc0_go && (gap == 4'd0);
    iss_stop  = can && f_stop;
    iss_l1    = can && !f_stop && f_l1;
    iss_start = can && !f_stop && !f_l1 && f_start;
    iss_user  = can && !f_stop && !f_l1
                && !f_start && f_user;
    nxt_cmd = 6'd0;
    nxt_stb = 1'b0;
    unique case (1'b1)
      bc0_go: begin
        nxt_cmd = 6'd1;
        nxt_stb = 1'b1;
      end
      iss_stop: begin
        nxt_cmd = 6'd7;
        nxt_stb = 1'b1;
      end
      iss_l1: begin
        nxt_cmd = 6'd3;
        nxt_stb = 1'b1;
      end
      iss_start: begin
        nxt_cmd = 6'd6;
        nxt_stb = 1'b1;
      end
      iss_user: begin
        nxt_cmd = ucode;
        nxt_stb = 1'b1;
      end
      default: ;
    endcase
  end

  // Orbit counter, pending flags, gap and bus registers.
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      orbit_bxn          <= '0;
      orbit_count        <= '0;
      bus.ccb_cmd        <= '0;
      bus.ccb_cmd_strobe <= 1'b0;
      bus.ccb_bc0        <= 1'b0;
      bus.dropped        <= 1'b0;
      f_stop             <= 1'b0;
      f_l1               <= 1'b0;
      f_start            <= 1'b0;
      f_user             <= 1'b0;
      ucode              <= '0;
      gap                <= '0;
    end else begin
      if (wrap) begin
        orbit_bxn   <= '0;
        orbit_count <= orbit_count + 16'd1;
      end else if (enable) begin
        orbit_bxn <= orbit_bxn + 12'd1;
      end
      bus.ccb_cmd        <= nxt_cmd;
      bus.ccb_cmd_strobe <= nxt_stb;
      bus.ccb_bc0        <= bc0_go;
      // a request in its own issue cycle re-arms
      f_stop  <= bus.req_stop
                 | (f_stop & ~iss_stop);
      f_l1    <= bus.req_l1reset
                 | (f_l1 & ~iss_l1);
      f_start <= bus.req_start
                 | (f_start & ~iss_start);
      f_user  <= bus.req_user
                 | (f_user & ~iss_user);
      bus.dropped <=
        (bus.req_stop    & f_stop  & ~iss_stop)
        | (bus.req_l1reset & f_l1    & ~iss_l1)
        | (bus.req_start   & f_start & ~iss_start)
        | (bus.req_user    & f_user  & ~iss_user);
      if (bus.req_user && (!f_user || iss_user))
        ucode <= bus.user_cmd;
      if (nxt_stb)
        gap <= GAP;
      else if (gap != 4'd0)
        gap <= gap - 4'd1;
    end
  end

endmodule

// File: tb/tb_ccb_cmd_gen.sv
// Scoreboard bench for ccb_cmd_gen against a
// cycle-stamped behavioural model.
module tb_ccb_cmd_gen;

  localparam int unsigned GAP = 2;

  logic        clk = 1'b0;
  logic        hard_rst = 1'b1;
  logic        sel = 1'b0;
  logic        enable = 1'b0;
  logic        bc0_en = 1'b0;
  logic [11:0] orbit_bxn;
  logic [15:0] orbit_count;

  ccb_cmd_gen_if bus ();

  ccb_cmd_gen #(.CMD_GAP(GAP)) dut (
    .clk           (clk),
    .hard_rst      (hard_rst),
    .lhc_cycle_sel (sel),
    .enable        (enable),
    .bc0_en        (bc0_en),
    .orbit_bxn     (orbit_bxn),
    .orbit_count   (orbit_count),
    .bus           (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic [5:0] cmd;
    logic       bc0;
  } stb_t;

  typedef struct {
    int          stamp;
    int          bxn;
    logic [15:0] cnt;
    logic        busy;
    logic        drop;
  } cyc_t;

  stb_t sq[$];
  cyc_t cq[$];

  int compared = 0;
  int mismatched = 0;

  // model state: pending slots in priority order
  // 0 stop, 1 l1reset, 2 start, 3 user
  int          m_bxn = 0;
  logic [15:0] m_cnt = 0;
  bit          pend[4];
  logic [5:0]  m_ucode = 0;
  int          m_last = -1000;

  function automatic void chk(string n, int a, int e);
    compared++;
    if (a != e) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d cycle %0d",
               n, a, e, cyc);
    end
  endfunction

  function automatic logic [5:0] code_of(int i);
    case (i)
      0: return 6'd7;
      1: return 6'd3;
      2: return 6'd6;
      default: return m_ucode;
    endcase
  endfunction

  // Predict the outputs seen in cycle cyc+1.
  task automatic model_step();
    bit   req[4];
    bit   iss[4];
    bit   drop;
    bit   sent;
    int   len;
    stb_t s;
    cyc_t r;
    req[0] = bus.req_stop;
    req[1] = bus.req_l1reset;
    req[2] = bus.req_start;
    req[3] = bus.req_user;
    iss = '{default: 0};
    drop = 0;
    if (hard_rst) begin
      m_bxn = 0;
      m_cnt = 0;
      pend = '{default: 0};
      m_ucode = 0;
      m_last = -1000;
    end else begin
      len = sel ? 3564 : 924;
      if (enable && bc0_en && m_bxn >= len - 1) begin
        s = '{cyc + 1, 6'd1, 1'b1};
        sq.push_back(s);
        m_last = cyc + 1;
      end else if (cyc - m_last >= int'(GAP)) begin
        sent = 0;
        for (int i = 0; i < 4; i++) begin
          if (pend[i] && !sent) begin
            s = '{cyc + 1, code_of(i), 1'b0};
            sq.push_back(s);
            pend[i] = 0;
            iss[i] = 1;
            sent = 1;
            m_last = cyc + 1;
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (pend[i] && !iss[i]) begin
            drop = 1;
          end else begin
            pend[i] = 1;
            if (i == 3) m_ucode = bus.user_cmd;
          end
        end
      end
      if (enable) begin
        if (m_bxn >= len - 1) begin
          m_bxn = 0;
          m_cnt = m_cnt + 16'd1;
        end else begin
          m_bxn = m_bxn + 1;
        end
      end
    end
    r.stamp = cyc + 1;
    r.bxn = m_bxn;
    r.cnt = m_cnt;
    r.busy = pend[0] | pend[1] | pend[2] | pend[3];
    r.drop = drop;
    cq.push_back(r);
  endtask

  // Monitor: compare DUT outputs mid-cycle.
  initial begin
    stb_t s;
    cyc_t r;
    forever begin
      @(negedge clk);
      while (sq.size() > 0 && sq[0].stamp < cyc) begin
        s = sq.pop_front();
        compared++;
        mismatched++;
        $display("FAIL stale_strobe: cmd %0d stamp %0d",
                 s.cmd, s.stamp);
      end
      if (bus.ccb_cmd_strobe) begin
        if (sq.size() > 0 && sq[0].stamp == cyc) begin
          s = sq.pop_front();
          chk("strobe_cmd", bus.ccb_cmd, s.cmd);
          chk("strobe_bc0", bus.ccb_bc0, s.bc0);
        end else begin
          compared++;
          mismatched++;
          $display("FAIL extra_strobe: got cmd %0d expected none cycle %0d",
                   bus.ccb_cmd, cyc);
        end
      end else if (sq.size() > 0 && sq[0].stamp == cyc) begin
        s = sq.pop_front();
        compared++;
        mismatched++;
        $display("FAIL missing_strobe: got none expected cmd %0d cycle %0d",
                 s.cmd, cyc);
      end
      if (cq.size() > 0 && cq[0].stamp == cyc) begin
        r = cq.pop_front();
        chk("orbit_bxn", orbit_bxn, r.bxn);
        chk("orbit_count", orbit_count, r.cnt);
        chk("busy", bus.busy, r.busy);
        chk("dropped", bus.dropped, r.drop);
        if (!bus.ccb_cmd_strobe) begin
          chk("idle_cmd", bus.ccb_cmd, 0);
          chk("idle_bc0", bus.ccb_bc0, 0);
        end
      end
    end
  end

  task automatic cyc1();
    model_step();
    @(negedge clk);
    bus.req_stop = 0;
    bus.req_l1reset = 0;
    bus.req_start = 0;
    bus.req_user = 0;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cyc1();
  endtask

  task automatic rand_run(int n, int pct);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(99) < pct) begin
        bus.req_stop    = $urandom_range(3) == 0;
        bus.req_l1reset = $urandom_range(3) == 0;
        bus.req_start   = $urandom_range(3) == 0;
        bus.req_user    = $urandom_range(1) == 0;
        bus.user_cmd    = 6'($urandom);
      end
      if ($urandom_range(299) == 0) enable = ~enable;
      if ($urandom_range(399) == 0) bc0_en = ~bc0_en;
      cyc1();
    end
  endtask

  task automatic run_to(int bx);
    for (int k = 0; k < 5000 && m_bxn != bx; k++)
      cyc1();
  endtask

  initial begin
    bus.req_stop = 0;
    bus.req_l1reset = 0;
    bus.req_start = 0;
    bus.req_user = 0;
    bus.user_cmd = 0;
    @(negedge clk);
    run(3);
    hard_rst = 0;
    enable = 1;
    bc0_en = 1;
    sel = 0;
    // three short orbits with no traffic
    run(924 * 3 + 5);
    // simultaneous stop / l1reset / start
    run_to(100);
    bus.req_stop = 1;
    bus.req_l1reset = 1;
    bus.req_start = 1;
    cyc1();
    run(12);
    // drop while pending, then re-arm in issue cycle
    bus.req_stop = 1;
    cyc1();
    bus.req_user = 1;
    bus.user_cmd = 6'h15;
    cyc1();
    bus.req_user = 1;
    bus.user_cmd = 6'h2A;
    cyc1();
    run(8);
    bus.req_user = 1;
    bus.user_cmd = 6'h15;
    cyc1();
    bus.req_user = 1;
    bus.user_cmd = 6'h33;
    cyc1();
    run(8);
    // l1reset lands on the BC0 slot
    run_to(922);
    bus.req_l1reset = 1;
    cyc1();
    run(8);
    // reset with start and user pending
    run_to(300);
    bus.req_stop = 1;
    cyc1();
    bus.req_start = 1;
    bus.req_user = 1;
    bus.user_cmd = 6'h3F;
    cyc1();
    hard_rst = 1;
    bus.req_l1reset = 1;
    cyc1();
    hard_rst = 0;
    run(10);
    // enable low holds the counter
    run_to(1000);
    enable = 0;
    run(20);
    enable = 1;
    // long orbit, then mid-orbit switch to short
    sel = 1;
    run(3564 * 3 + 5);
    run_to(2000);
    sel = 0;
    run(10);
    // randomized traffic
    rand_run(4000, 20);
    enable = 1;
    bc0_en = 1;
    sel = $urandom_range(1);
    rand_run(4000, 10);
    run(GAP + 20);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
